// File: rtl/branch_stack_pkg.sv
// Shared definitions for the branch checkpoint stack.
//   BR_TASK    : resolution command from the branch FU (NOTHING / CLEAR / SQUASH)
//   BR_MASK    : one-hot branch tag / dependency mask, one bit per checkpoint
//   CHECKPOINT : rename state captured when a branch dispatches
package branch_stack_pkg;

  localparam int BR_STACK_DEPTH = 4;
  localparam int ARCH_REGS      = 32;
  localparam int PR_W           = 6;
  localparam int FL_PTR_W       = 6;
  localparam int MAP_W          = ARCH_REGS * PR_W;

  typedef enum logic [1:0] {
    NOTHING = 2'd0,
    CLEAR   = 2'd1,
    SQUASH  = 2'd2
  } BR_TASK;

  typedef logic [BR_STACK_DEPTH-1:0] BR_MASK;

  typedef struct packed {
    logic [MAP_W-1:0]    map;
    logic [FL_PTR_W-1:0] fl_head;
    logic [31:0]         pc;
  } CHECKPOINT;

endpackage

// File: rtl/branch_stack_psel_lowest.sv
// Lowest-set-bit priority selector.
//   req : request vector
//   gnt : one-hot grant of the lowest-index set bit of req, zero when req is zero
module psel_lowest #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] gnt
);

  // Two's complement isolates the lowest set bit.
  assign gnt = req & (~req + {{(WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/branch_stack.sv
// Checkpoint store for in-flight conditional branches.
//
// Dispatch allocates one checkpoint per branch (map snapshot, free-list head,
// recovery PC). The branch FU resolves branches by tag: CLEAR retires the
// checkpoint and broadcasts the tag; SQUASH restores the rename state of the
// resolving branch and kills it plus every younger branch.
//
// Allocation handshake: alloc_en is the request and full is the inverse of
// ready. A checkpoint is taken on a rising clock edge exactly when
// alloc_en && !full; alloc_tag/alloc_mask describe that checkpoint in the same
// cycle. When full is high the request is simply not taken and dispatch must
// hold the branch and present it again.
//
// Ports:
//   clock, reset                synchronous active-high reset
//   alloc_en/map/fl_head/pc     allocation request and snapshot payload
//   alloc_tag, alloc_mask, full combinational grant, live-branch mask, stall
//   br_task, br_tag, br_target  resolution command from the branch FU
//   clear_valid, clear_tag      registered CLEAR broadcast (1-cycle pulse)
//   restore_*                   registered SQUASH recovery data (1-cycle pulse)
//   squash_mask                 registered set of killed tags
module branch_stack
  import branch_stack_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                alloc_en,
  input  logic [MAP_W-1:0]    alloc_map,
  input  logic [FL_PTR_W-1:0] alloc_fl_head,
  input  logic [31:0]         alloc_pc,
  output BR_MASK              alloc_tag,
  output BR_MASK              alloc_mask,
  output logic                full,
  input  BR_TASK              br_task,
  input  BR_MASK              br_tag,
  input  logic [31:0]         br_target,
  output logic                clear_valid,
  output BR_MASK              clear_tag,
  output logic                restore_valid,
  output logic [MAP_W-1:0]    restore_map,
  output logic [FL_PTR_W-1:0] restore_fl_head,
  output logic [31:0]         restore_pc,
  output BR_MASK              squash_mask
);

  BR_MASK    valid;
  BR_MASK    dep_mask [BR_STACK_DEPTH];
  CHECKPOINT ckpt     [BR_STACK_DEPTH];

  BR_MASK    free_gnt;
  BR_MASK    younger;
  BR_MASK    squash_set;
  BR_MASK    kill_set;
  CHECKPOINT sel_ckpt;
  logic      br_hit;
  logic      do_clear;
  logic      do_squash;
  logic      alloc_fire;

  psel_lowest #(
    .WIDTH(BR_STACK_DEPTH)
  ) u_alloc_sel (
    .req(~valid),
    .gnt(free_gnt)
  );

  // Resolution decode. A command on a dead or non-one-hot tag is ignored.
  always_comb begin
    br_hit    = $onehot(br_tag) && ((br_tag & valid) != '0);
    do_clear  = (br_task == CLEAR)  && br_hit;
    do_squash = (br_task == SQUASH) && br_hit;

    younger  = '0;
    sel_ckpt = '0;
    for (int e = 0; e < BR_STACK_DEPTH; e++) begin
      // An entry is younger than the resolving branch iff it depends on it.
      if (valid[e] && ((dep_mask[e] & br_tag) != '0)) younger[e] = 1'b1;
      if (br_tag[e]) sel_ckpt = ckpt[e];
    end
    squash_set = br_tag | younger;

    if (do_squash)     kill_set = squash_set;
    else if (do_clear) kill_set = br_tag;
    else               kill_set = '0;
  end

  // Allocation side. A squash cycle stalls dispatch so the redirect can win.
  always_comb begin
    full       = do_squash | (&valid);
    alloc_tag  = do_squash ? '0 : free_gnt;
    alloc_mask = valid & ~(do_clear ? br_tag : '0);
    alloc_fire = alloc_en & ~full;
  end

  // Entry valid bits and dependency masks.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= '0;
      for (int e = 0; e < BR_STACK_DEPTH; e++) dep_mask[e] <= '0;
    end else begin
      for (int e = 0; e < BR_STACK_DEPTH; e++) begin
        if (alloc_fire && free_gnt[e]) begin
          valid[e]    <= 1'b1;
          dep_mask[e] <= alloc_mask;
        end else begin
          valid[e]    <= valid[e] & ~kill_set[e];
          dep_mask[e] <= dep_mask[e] & ~kill_set;
        end
      end
    end
  end

  // Snapshot payload; only meaningful while the matching valid bit is set.
  always_ff @(posedge clock) begin
    for (int e = 0; e < BR_STACK_DEPTH; e++) begin
      if (alloc_fire && free_gnt[e]) begin
        ckpt[e].map     <= alloc_map;
        ckpt[e].fl_head <= alloc_fl_head;
        ckpt[e].pc      <= alloc_pc;
      end
    end
  end

  // Registered resolution outputs: one-cycle pulses, data zero when idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      clear_valid     <= 1'b0;
      clear_tag       <= '0;
      restore_valid   <= 1'b0;
      restore_map     <= '0;
      restore_fl_head <= '0;
      restore_pc      <= '0;
      squash_mask     <= '0;
    end else begin
      clear_valid     <= do_clear;
      clear_tag       <= do_clear ? br_tag : '0;
      restore_valid   <= do_squash;
      restore_map     <= do_squash ? sel_ckpt.map : '0;
      restore_fl_head <= do_squash ? sel_ckpt.fl_head : '0;
      restore_pc      <= do_squash ? br_target : '0;
      squash_mask     <= do_squash ? squash_set : '0;
    end
  end

  // The stored recovery PC is kept for debug visibility; the redirect uses
  // the FU's resolved target instead.
  logic unused_pc;
  assign unused_pc = ^sel_ckpt.pc;

  always @(posedge clock) begin
    if (!reset && (br_task != NOTHING)) begin
      assert (br_hit)
        else $error("branch_stack: br_task on dead or non-one-hot tag %b", br_tag);
    end
  end

endmodule
